// File: rtl/serv_ram_pkg.sv
// Shared definitions for the SERV <-> RAM32 bridge: FSM encoding, default
// RAM depth and the address range helper.
package serv_ram_pkg;

    localparam int DEFAULT_AW = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESP_I = 2'd1,
        ST_RESP_D = 2'd2
    } state_e;

    // An address is usable only if every bit above the word index is zero.
    function automatic logic in_range(input logic [31:0] adr, input int aw);
        return (adr >> (aw + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/serv_ram_bridge_if.sv
// SERV instruction and data bus bundle; master = CPU side, slave = bridge side.
interface serv_ram_bridge_if;

    logic        ibus_cyc;
    logic [31:0] ibus_adr;
    logic [31:0] ibus_rdt;
    logic        ibus_ack;

    logic        dbus_cyc;
    logic [31:0] dbus_adr;
    logic        dbus_we;
    logic [31:0] dbus_dat;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;

    modport master (
        output ibus_cyc, ibus_adr,
        input  ibus_rdt, ibus_ack,
        output dbus_cyc, dbus_adr, dbus_we, dbus_dat, dbus_sel,
        input  dbus_rdt, dbus_ack
    );

    modport slave (
        input  ibus_cyc, ibus_adr,
        output ibus_rdt, ibus_ack,
        input  dbus_cyc, dbus_adr, dbus_we, dbus_dat, dbus_sel,
        output dbus_rdt, dbus_ack
    );

endinterface

// File: rtl/serv_ram_bridge.sv
// Arbitrates SERV ibus/dbus onto a single-port RAM32 macro with a registered
// read port; every access takes one grant cycle plus one response cycle.
module serv_ram_bridge
    import serv_ram_pkg::*;
#(
    parameter int AW = DEFAULT_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    serv_ram_bridge_if.slave  bus,
    output logic              ram_en,
    output logic [AW-1:0]     ram_a,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_di,
    input  logic [31:0]       ram_do,
    output logic              err
);

    state_e      state_q, state_d;
    logic        dwe_q, dwe_d;
    logic        oor_q, oor_d;
    logic        err_q, err_d;

    logic        grant_dbus;
    logic        grant_ibus;
    logic        adr_ok;
    logic [31:0] sel_adr;
    logic        ibus_ack_w;
    logic        dbus_ack_w;

    // Byte-offset bits carry no meaning for a word-wide RAM.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{bus.ibus_adr[1:0], bus.dbus_adr[1:0]};

    always_comb begin
        grant_dbus = rst_n && (state_q == ST_IDLE) && bus.dbus_cyc;
        grant_ibus = rst_n && (state_q == ST_IDLE) && !bus.dbus_cyc && bus.ibus_cyc;
        sel_adr    = grant_dbus ? bus.dbus_adr : bus.ibus_adr;
        adr_ok     = in_range(sel_adr, AW);

        state_d = state_q;
        dwe_d   = dwe_q;
        oor_d   = oor_q;
        err_d   = err_q;

        if (!rst_n) begin
            state_d = ST_IDLE;
            dwe_d   = 1'b0;
            oor_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_dbus) begin
                        state_d = ST_RESP_D;
                        dwe_d   = bus.dbus_we;
                        oor_d   = !adr_ok;
                    end else if (grant_ibus) begin
                        state_d = ST_RESP_I;
                        dwe_d   = 1'b0;
                        oor_d   = !adr_ok;
                    end
                    if ((grant_dbus || grant_ibus) && !adr_ok) begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // RAM strobes are driven straight from the grant so the macro samples
    // them at the end of the grant cycle; out-of-range accesses never reach it.
    always_comb begin
        ram_en = (grant_dbus || grant_ibus) && adr_ok;
        ram_a  = sel_adr[AW+1:2];
        ram_we = (grant_dbus && bus.dbus_we && adr_ok) ? bus.dbus_sel : 4'b0000;
        ram_di = (grant_dbus && bus.dbus_we) ? bus.dbus_dat : 32'd0;
    end

    always_comb begin
        ibus_ack_w   = rst_n && (state_q == ST_RESP_I);
        dbus_ack_w   = rst_n && (state_q == ST_RESP_D);
        bus.ibus_ack = ibus_ack_w;
        bus.dbus_ack = dbus_ack_w;
        bus.ibus_rdt = (ibus_ack_w && !oor_q) ? ram_do : 32'd0;
        bus.dbus_rdt = (dbus_ack_w && !oor_q && !dwe_q) ? ram_do : 32'd0;
        err          = err_q;
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        dwe_q   <= dwe_d;
        oor_q   <= oor_d;
        err_q   <= err_d;
    end

endmodule

// File: tb/tb_serv_ram_bridge.sv
// Directed bench for serv_ram_bridge: drivers push expected responses into
// per-bus queues, a negedge monitor pops and compares on each acknowledge.
module tb_serv_ram_bridge;
    import serv_ram_pkg::*;

    localparam int AW = 5;

    typedef struct packed {
        logic [31:0] rdt;
        logic [31:0] cyc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          ram_en;
    logic [AW-1:0] ram_a;
    logic [3:0]    ram_we;
    logic [31:0]   ram_di;
    logic [31:0]   ram_do;
    logic          err;

    serv_ram_bridge_if bus();

    serv_ram_bridge #(.AW(AW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .ram_en (ram_en),
        .ram_a  (ram_a),
        .ram_we (ram_we),
        .ram_di (ram_di),
        .ram_do (ram_do),
        .err    (err)
    );

    // Behavioural RAM32: byte-write, registered read output.
    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_a][b*8 +: 8] <= ram_di[b*8 +: 8];
            end
            ram_do <= mem[ram_a];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t dq[$];
    exp_t iq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Monitor: one line per acknowledged transaction.
    always @(negedge clk) begin
        exp_t e;
        if (bus.ibus_ack && bus.dbus_ack) chk("both_acks", 32'd1, 32'd0);
        if (bus.dbus_ack) begin
            if (dq.size() == 0) chk("d_unexpected_ack", 32'd1, 32'd0);
            else begin
                e = dq.pop_front();
                $display("dbus ack cycle %0d rdt %h", cyc_cnt, bus.dbus_rdt);
                chk("d_rdt", bus.dbus_rdt, e.rdt);
                chk("d_ack_cycle", 32'(cyc_cnt), e.cyc);
            end
        end else begin
            chk("d_rdt_idle", bus.dbus_rdt, 32'd0);
        end
        if (bus.ibus_ack) begin
            if (iq.size() == 0) chk("i_unexpected_ack", 32'd1, 32'd0);
            else begin
                e = iq.pop_front();
                $display("ibus ack cycle %0d rdt %h", cyc_cnt, bus.ibus_rdt);
                chk("i_rdt", bus.ibus_rdt, e.rdt);
                chk("i_ack_cycle", 32'(cyc_cnt), e.cyc);
            end
        end else begin
            chk("i_rdt_idle", bus.ibus_rdt, 32'd0);
        end
        if (bus.ibus_ack || bus.dbus_ack) begin
            chk("resp_ram_en", 32'(ram_en), 32'd0);
            chk("resp_ram_we", 32'(ram_we), 32'd0);
        end
    end

    task automatic do_d(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] exp_rdt, input int lat,
                        input logic chk_g, input logic exp_en, input logic [3:0] exp_we,
                        input logic drop);
        bit got = 0;
        bus.dbus_cyc = 1'b1;
        bus.dbus_we  = we;
        bus.dbus_adr = adr;
        bus.dbus_dat = dat;
        bus.dbus_sel = sel;
        dq.push_back('{rdt: exp_rdt, cyc: 32'(cyc_cnt + lat)});
        if (chk_g) begin
            @(negedge clk);
            chk("d_grant_en", 32'(ram_en), 32'(exp_en));
            chk("d_grant_we", 32'(ram_we), 32'(exp_we));
            if (exp_en) chk("d_grant_a", 32'(ram_a), 32'(adr[AW+1:2]));
            if (exp_en && we) chk("d_grant_di", ram_di, dat);
        end
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (bus.dbus_ack) got = 1;
        end
        if (!got) chk("d_ack_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (drop) begin
            bus.dbus_cyc = 1'b0;
            bus.dbus_we  = 1'b0;
        end
    endtask

    task automatic do_i(input logic [31:0] adr, input logic [31:0] exp_rdt, input int lat,
                        input logic chk_g, input logic drop);
        bit got = 0;
        bus.ibus_cyc = 1'b1;
        bus.ibus_adr = adr;
        iq.push_back('{rdt: exp_rdt, cyc: 32'(cyc_cnt + lat)});
        if (chk_g) begin
            @(negedge clk);
            chk("i_grant_en", 32'(ram_en), 32'd1);
            chk("i_grant_a", 32'(ram_a), 32'(adr[AW+1:2]));
            chk("i_grant_we", 32'(ram_we), 32'd0);
        end
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (bus.ibus_ack) got = 1;
        end
        if (!got) chk("i_ack_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (drop) bus.ibus_cyc = 1'b0;
    endtask

    function automatic logic [31:0] fetch_exp(input int w);
        case (w)
            2:       return 32'hDEAD55EF;
            4:       return 32'hCAFEF00D;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        for (int w = 0; w < 32; w++) mem[w] = 32'd0;
        ram_do       = 32'd0;
        rst_n        = 1'b0;
        bus.ibus_cyc = 1'b1;
        bus.ibus_adr = 32'h0000_0004;
        bus.dbus_cyc = 1'b1;
        bus.dbus_adr = 32'h0000_0008;
        bus.dbus_we  = 1'b1;
        bus.dbus_dat = 32'hFFFF_FFFF;
        bus.dbus_sel = 4'hF;

        // Reset held with both buses requesting: nothing may leak out.
        repeat (3) begin
            @(negedge clk);
            chk("rst_ram_en", 32'(ram_en), 32'd0);
            chk("rst_ram_we", 32'(ram_we), 32'd0);
            chk("rst_acks", 32'({bus.ibus_ack, bus.dbus_ack}), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.ibus_cyc = 1'b0;
        bus.dbus_cyc = 1'b0;
        bus.dbus_we  = 1'b0;
        rst_n        = 1'b1;
        @(posedge clk);
        #1;

        do_d(1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'd0,        1, 1'b1, 1'b1, 4'hF, 1'b1);
        do_d(1'b0, 32'h08, 32'd0,        4'hF, 32'hDEADBEEF, 1, 1'b1, 1'b1, 4'h0, 1'b1);
        do_d(1'b1, 32'h08, 32'h00005500, 4'h2, 32'd0,        1, 1'b1, 1'b1, 4'h2, 1'b1);
        do_d(1'b0, 32'h08, 32'd0,        4'hF, 32'hDEAD55EF, 1, 1'b1, 1'b1, 4'h0, 1'b1);
        do_d(1'b1, 32'h0C, 32'h12345678, 4'h0, 32'd0,        1, 1'b1, 1'b1, 4'h0, 1'b1);
        do_d(1'b0, 32'h0F, 32'd0,        4'hF, 32'd0,        1, 1'b1, 1'b1, 4'h0, 1'b1);
        do_d(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 32'd0,        1, 1'b1, 1'b1, 4'hF, 1'b1);

        // Both buses request in the same cycle: dbus first, ibus two cycles later.
        fork
            do_d(1'b0, 32'h10, 32'd0, 4'hF, 32'hCAFEF00D, 1, 1'b1, 1'b1, 4'h0, 1'b1);
            do_i(32'h0B, 32'hDEAD55EF, 3, 1'b0, 1'b1);
        join

        // Back-to-back fetch sweep over the whole RAM.
        for (int w = 0; w < 32; w++) begin
            do_i(32'(w * 4), fetch_exp(w), 1, 1'b1, (w == 31));
        end

        // Load a non-zero value into ram_do so a zero out-of-range rdt means something.
        do_d(1'b0, 32'h08, 32'd0, 4'hF, 32'hDEAD55EF, 1, 1'b1, 1'b1, 4'h0, 1'b1);
        chk("err_before_oor", 32'(err), 32'd0);
        do_d(1'b0, 32'h80, 32'd0, 4'hF, 32'd0, 1, 1'b1, 1'b0, 4'h0, 1'b1);
        do_d(1'b1, 32'h0000_1000, 32'h5A5A5A5A, 4'hF, 32'd0, 1, 1'b1, 1'b0, 4'h0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("err_sticky", 32'(err), 32'd1);
        end
        @(posedge clk);
        #1;
        do_d(1'b0, 32'h00, 32'd0, 4'hF, 32'd0, 1, 1'b1, 1'b1, 4'h0, 1'b1);

        // Reset while the data response is pending.
        bus.dbus_cyc = 1'b1;
        bus.dbus_we  = 1'b0;
        bus.dbus_adr = 32'h10;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_ack", 32'(bus.dbus_ack), 32'd0);
        chk("rst_mid_en", 32'(ram_en), 32'd0);
        @(posedge clk);
        #1;
        bus.dbus_cyc = 1'b0;
        rst_n        = 1'b1;
        @(negedge clk);
        chk("rst_mid_err", 32'(err), 32'd0);
        chk("rst_mid_idle_ack", 32'(bus.dbus_ack), 32'd0);
        @(posedge clk);
        #1;
        do_d(1'b0, 32'h10, 32'd0, 4'hF, 32'hCAFEF00D, 1, 1'b1, 1'b1, 4'h0, 1'b1);

        repeat (2) @(negedge clk);
        chk("dq_drained", 32'(dq.size()), 32'd0);
        chk("iq_drained", 32'(iq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
